// File: rtl/csr_pkg.sv
// Shared CSR constants: architectural addresses, Zicsr funct3 encodings,
// privilege levels and the access-unit state encoding.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
  localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
  localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
  localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
  localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
  localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

  // Operation selector is funct3[1:0]; 2'b00 is not a CSR access.
  localparam logic [1:0] CSR_OP_NONE = 2'b00;
  localparam logic [1:0] CSR_OP_RW   = 2'b01;
  localparam logic [1:0] CSR_OP_RS   = 2'b10;
  localparam logic [1:0] CSR_OP_RC   = 2'b11;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_WR      = 3'd2;
  localparam logic [2:0] ST_RSP     = 3'd3;
  localparam logic [2:0] ST_T_EPC   = 3'd4;
  localparam logic [2:0] ST_T_CAUSE = 3'd5;
  localparam logic [2:0] ST_T_VEC   = 3'd6;
  localparam logic [2:0] ST_T_DONE  = 3'd7;

endpackage

// File: rtl/csr_access_unit_if.sv
// Read/write port bundle between the CSR access unit (master) and the CSR file (slave).
interface csr_access_unit_if #(
  parameter int unsigned XLEN = 64
);
  logic [11:0]     CSR_SR;
  logic [XLEN-1:0] CSR_RDATA;
  logic [11:0]     CSR_DR;
  logic [XLEN-1:0] CSR_DATA;
  logic            CSR_LD_REG;

  modport master (
    output CSR_SR,
    input  CSR_RDATA,
    output CSR_DR,
    output CSR_DATA,
    output CSR_LD_REG
  );

  modport slave (
    input  CSR_SR,
    output CSR_RDATA,
    input  CSR_DR,
    input  CSR_DATA,
    input  CSR_LD_REG
  );
endinterface

// File: rtl/csr_access_unit_alu.sv
// Combinational CSR data merge (RW/RS/RC) and access legality check.
module csr_alu
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [1:0]      op,
  input  logic [3:0]      addr_hi,
  input  logic [1:0]      privilege,
  input  logic            rs1_nz,
  input  logic [XLEN-1:0] operand,
  input  logic [XLEN-1:0] old_data,
  output logic [XLEN-1:0] wdata,
  output logic            write_req,
  output logic            illegal
);

  // Legality: addr_hi[3:2]==11 marks read-only space, addr_hi[1:0] is the minimum privilege.
  always_comb begin
    write_req = (op == CSR_OP_RW) | rs1_nz;
    illegal   = (op == CSR_OP_NONE)
              | (addr_hi[1:0] > privilege)
              | ((addr_hi[3:2] == 2'b11) & write_req);
  end

  // Write-data merge against the value read in the previous cycle.
  always_comb begin
    wdata = old_data;
    unique case (op)
      CSR_OP_RW: wdata = operand;
      CSR_OP_RS: wdata = old_data | operand;
      CSR_OP_RC: wdata = old_data & ~operand;
      default:   wdata = old_data;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: sequences Zicsr read-modify-write accesses and trap entry
// (mepc/mcause writes, mtvec read, redirect target) over the CSR file ports.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter logic [11:0] MEPC_ADDR   = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR = CSR_MCAUSE,
  parameter logic [11:0] MTVEC_ADDR  = CSR_MTVEC
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [2:0]      FUNCT3,
  input  logic [11:0]     CSR_ADDR,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [4:0]      ZIMM,
  input  logic            RS1_NZ,
  input  logic [1:0]      PRIVILEGE,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [XLEN-1:0] RSP_DATA,
  output logic            RSP_ILLEGAL,
  input  logic            TRAP_REQ,
  input  logic [XLEN-1:0] TRAP_CAUSE,
  input  logic [XLEN-1:0] TRAP_PC,
  output logic            TRAP_DONE,
  output logic [XLEN-1:0] TRAP_TARGET,
  csr_access_unit_if.master csr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [2:0]      state_q;
  logic [1:0]      op_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] operand_q;
  logic            nz_q;
  logic [1:0]      priv_q;
  logic [XLEN-1:0] old_q;
  logic            ill_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;

  logic [XLEN-1:0] alu_wdata;
  logic            alu_write_req;
  logic            alu_illegal;
  logic [XLEN-1:0] req_operand;
  logic [XLEN-1:0] vec_target;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op        (op_q),
    .addr_hi   (addr_q[11:8]),
    .privilege (priv_q),
    .rs1_nz    (nz_q),
    .operand   (operand_q),
    .old_data  (old_q),
    .wdata     (alu_wdata),
    .write_req (alu_write_req),
    .illegal   (alu_illegal)
  );

  // Immediate forms take zero-extended zimm, register forms take rs1.
  always_comb begin
    req_operand = FUNCT3[2] ? {{(XLEN-5){1'b0}}, ZIMM} : RS1_DATA;
  end

  // Trap vector: vectored mode only for interrupts; mode 1x behaves as direct.
  always_comb begin
    vec_target = csr.CSR_RDATA & ALIGN_MASK;
    if ((csr.CSR_RDATA[1:0] == 2'b01) && cause_q[XLEN-1])
      vec_target = (csr.CSR_RDATA & ALIGN_MASK)
                 + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00};
  end

  // Sequencer state and per-transaction capture registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      operand_q <= '0;
      nz_q      <= 1'b0;
      priv_q    <= '0;
      old_q     <= '0;
      ill_q     <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      target_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (TRAP_REQ) begin
            cause_q <= TRAP_CAUSE;
            pc_q    <= TRAP_PC;
            state_q <= ST_T_EPC;
          end else if (REQ_VALID) begin
            op_q      <= FUNCT3[1:0];
            addr_q    <= CSR_ADDR;
            operand_q <= req_operand;
            nz_q      <= RS1_NZ;
            priv_q    <= PRIVILEGE;
            state_q   <= ST_RD;
          end
        end
        ST_RD: begin
          old_q   <= csr.CSR_RDATA;
          ill_q   <= alu_illegal;
          state_q <= (alu_illegal || !alu_write_req) ? ST_RSP : ST_WR;
        end
        ST_WR:      state_q <= ST_RSP;
        ST_RSP:     if (RSP_READY) state_q <= ST_IDLE;
        ST_T_EPC:   state_q <= ST_T_CAUSE;
        ST_T_CAUSE: state_q <= ST_T_VEC;
        ST_T_VEC: begin
          target_q <= vec_target;
          state_q  <= ST_T_DONE;
        end
        ST_T_DONE:  state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake and trap outputs decoded from state; RST_N gates ready during reset.
  always_comb begin
    REQ_READY   = RST_N && (state_q == ST_IDLE) && !TRAP_REQ;
    RSP_VALID   = (state_q == ST_RSP);
    RSP_DATA    = old_q;
    RSP_ILLEGAL = (state_q == ST_RSP) && ill_q;
    TRAP_DONE   = (state_q == ST_T_DONE);
    TRAP_TARGET = target_q;
  end

  // CSR file port drive; the write strobe exists only in WR, T_EPC and T_CAUSE.
  always_comb begin
    csr.CSR_SR     = '0;
    csr.CSR_DR     = '0;
    csr.CSR_DATA   = '0;
    csr.CSR_LD_REG = 1'b0;
    case (state_q)
      ST_RD:    csr.CSR_SR = addr_q;
      ST_T_VEC: csr.CSR_SR = MTVEC_ADDR;
      ST_WR: begin
        csr.CSR_DR     = addr_q;
        csr.CSR_DATA   = alu_wdata;
        csr.CSR_LD_REG = 1'b1;
      end
      ST_T_EPC: begin
        csr.CSR_DR     = MEPC_ADDR;
        csr.CSR_DATA   = pc_q & ALIGN_MASK;
        csr.CSR_LD_REG = 1'b1;
      end
      ST_T_CAUSE: begin
        csr.CSR_DR     = MCAUSE_ADDR;
        csr.CSR_DATA   = cause_q;
        csr.CSR_LD_REG = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit with a behavioural CSR file and reference model.
module tb_csr_access_unit;

  logic        CLK;
  logic        RST_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  FUNCT3;
  logic [11:0] CSR_ADDR;
  logic [63:0] RS1_DATA;
  logic [4:0]  ZIMM;
  logic        RS1_NZ;
  logic [1:0]  PRIVILEGE;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [63:0] RSP_DATA;
  logic        RSP_ILLEGAL;
  logic        TRAP_REQ;
  logic [63:0] TRAP_CAUSE;
  logic [63:0] TRAP_PC;
  logic        TRAP_DONE;
  logic [63:0] TRAP_TARGET;

  csr_access_unit_if #(.XLEN(64)) bus ();

  csr_access_unit #(
    .XLEN        (64),
    .MEPC_ADDR   (12'h341),
    .MCAUSE_ADDR (12'h342),
    .MTVEC_ADDR  (12'h305)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .FUNCT3      (FUNCT3),
    .CSR_ADDR    (CSR_ADDR),
    .RS1_DATA    (RS1_DATA),
    .ZIMM        (ZIMM),
    .RS1_NZ      (RS1_NZ),
    .PRIVILEGE   (PRIVILEGE),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_DATA    (RSP_DATA),
    .RSP_ILLEGAL (RSP_ILLEGAL),
    .TRAP_REQ    (TRAP_REQ),
    .TRAP_CAUSE  (TRAP_CAUSE),
    .TRAP_PC     (TRAP_PC),
    .TRAP_DONE   (TRAP_DONE),
    .TRAP_TARGET (TRAP_TARGET),
    .csr         (bus.master)
  );

  // CSR file storage (written by DUT) and the model's own expected contents.
  logic [63:0] mem     [4096];
  logic [63:0] ref_mem [4096];
  logic [75:0] wq [$];
  int n_checks;
  int n_pass;

  assign bus.CSR_RDATA = mem[bus.CSR_SR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [63:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // One Zicsr instruction: model computes the architectural outcome, bench drives and compares.
  task automatic do_csr(input logic [2:0] f3, input logic [11:0] a, input logic [63:0] rs1,
                        input logic [4:0] zi, input logic nz, input logic [1:0] pv,
                        input int hold);
    logic [63:0] opnd, old_e, new_e;
    logic        wreq, ill, wr_e;
    int          lat, t;
    opnd  = f3[2] ? {59'd0, zi} : rs1;
    wreq  = (f3[1:0] == 2'b01) || nz;
    ill   = (f3[1:0] == 2'b00) || (a[9:8] > pv) || ((a[11:10] == 2'b11) && wreq);
    old_e = ref_mem[a];
    wr_e  = !ill && wreq;
    case (f3[1:0])
      2'b01:   new_e = opnd;
      2'b10:   new_e = old_e | opnd;
      default: new_e = old_e & ~opnd;
    endcase
    wq.delete();
    @(negedge CLK);
    REQ_VALID = 1'b1; FUNCT3 = f3; CSR_ADDR = a; RS1_DATA = rs1;
    ZIMM = zi; RS1_NZ = nz; PRIVILEGE = pv;
    t = 0;
    while (!REQ_READY && t < 20) begin @(negedge CLK); t++; end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 10) begin @(posedge CLK); #1; lat++; end
    check("latency", 64'(lat), wr_e ? 64'd3 : 64'd2);
    check("rsp_data", RSP_DATA, old_e);
    check("rsp_illegal", {63'd0, RSP_ILLEGAL}, {63'd0, ill});
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check("rsp_hold_valid", {63'd0, RSP_VALID}, 64'd1);
      check("rsp_hold_data", RSP_DATA, old_e);
    end
    @(negedge CLK);
    RSP_READY = 1'b1;
    check("ready_during_rsp", {63'd0, REQ_READY}, 64'd0);
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    check("rsp_after_hs", {63'd0, RSP_VALID}, 64'd0);
    check("write_count", 64'(wq.size()), wr_e ? 64'd1 : 64'd0);
    if (wr_e && wq.size() > 0) begin
      check("write_addr", {52'd0, wq[0][75:64]}, {52'd0, a});
      check("write_data", wq[0][63:0], new_e);
    end
    if (wr_e) ref_mem[a] = new_e;
  endtask

  // One trap entry: expected target derived from the mtvec mode/base rules.
  task automatic do_trap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] mtvec);
    logic [63:0] base, tgt;
    int n;
    set_csr(12'h305, mtvec);
    base = mtvec & ~64'd3;
    tgt  = ((mtvec[1:0] == 2'b01) && cause[63]) ? base + 64'd4 * (cause % 64) : base;
    wq.delete();
    @(negedge CLK);
    TRAP_REQ = 1'b1; TRAP_CAUSE = cause; TRAP_PC = pc;
    #1;
    check("ready_with_trap", {63'd0, REQ_READY}, 64'd0);
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (!TRAP_DONE && n < 12);
    TRAP_REQ = 1'b0;
    check("trap_latency", 64'(n), 64'd4);
    check("trap_target", TRAP_TARGET, tgt);
    check("trap_writes", 64'(wq.size()), 64'd2);
    if (wq.size() >= 2) begin
      check("mepc_addr", {52'd0, wq[0][75:64]}, 64'h341);
      check("mepc_data", wq[0][63:0], pc & ~64'd3);
      check("mcause_addr", {52'd0, wq[1][75:64]}, 64'h342);
      check("mcause_data", wq[1][63:0], cause);
    end
    @(posedge CLK); #1;
    check("trap_done_pulse", {63'd0, TRAP_DONE}, 64'd0);
    check("trap_target_held", TRAP_TARGET, tgt);
    check("ready_after_trap", {63'd0, REQ_READY}, 64'd1);
    ref_mem[12'h341] = pc & ~64'd3;
    ref_mem[12'h342] = cause;
  endtask

  initial begin
    logic [11:0] pool [8];
    logic [1:0]  privs [3];
    n_checks = 0; n_pass = 0;
    RST_N = 1'b0; REQ_VALID = 1'b0; FUNCT3 = '0; CSR_ADDR = '0; RS1_DATA = '0;
    ZIMM = '0; RS1_NZ = 1'b0; PRIVILEGE = '0; RSP_READY = 1'b0;
    TRAP_REQ = 1'b0; TRAP_CAUSE = '0; TRAP_PC = '0;
    for (int unsigned i = 0; i < 4096; i++) set_csr(12'(i), {$urandom, $urandom});

    // Write monitor: log every strobe mid-cycle and commit it to the file model.
    fork
      forever begin
        @(negedge CLK);
        if (bus.CSR_LD_REG) begin
          wq.push_back({bus.CSR_DR, bus.CSR_DATA});
          mem[bus.CSR_DR] = bus.CSR_DATA;
        end
      end
    join_none

    #12;
    check("rst_req_ready", {63'd0, REQ_READY}, 64'd0);
    check("rst_rsp_valid", {63'd0, RSP_VALID}, 64'd0);
    check("rst_ld_reg", {63'd0, bus.CSR_LD_REG}, 64'd0);
    check("rst_rsp_data", RSP_DATA, 64'd0);
    check("rst_target", TRAP_TARGET, 64'd0);
    check("rst_csr_sr", {52'd0, bus.CSR_SR}, 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("ready_after_rst", {63'd0, REQ_READY}, 64'd1);

    // Directed cases.
    set_csr(12'h340, 64'h1234);
    do_csr(3'b001, 12'h340, 64'hDEAD, 5'd0, 1'b1, 2'd3, 0);
    do_csr(3'b010, 12'hC00, 64'h1, 5'd0, 1'b0, 2'd3, 1);
    do_csr(3'b010, 12'hC00, 64'h1, 5'd0, 1'b1, 2'd3, 0);
    set_csr(12'h340, 64'hFF);
    do_csr(3'b111, 12'h340, 64'h0, 5'b00101, 1'b1, 2'd3, 2);
    do_csr(3'b001, 12'h300, 64'h77, 5'd0, 1'b1, 2'd0, 0);
    do_csr(3'b100, 12'h340, 64'h77, 5'd3, 1'b1, 2'd3, 0);
    do_trap(64'h8000_0000_0000_0007, 64'h8000_0102, 64'h1001);
    do_trap(64'h8000_0000_0000_0007, 64'h8000_0102, 64'h1000);

    // Randomized traffic over a mix of privilege levels and read-only space.
    pool  = '{12'h340, 12'hC00, 12'h300, 12'h100, 12'h140, 12'h7C0, 12'h200, 12'hF11};
    privs = '{2'd0, 2'd1, 2'd3};
    for (int i = 0; i < 40; i++)
      do_csr(3'($urandom_range(0, 7)), pool[$urandom_range(0, 7)], {$urandom, $urandom},
             5'($urandom), 1'($urandom), privs[$urandom_range(0, 2)],
             int'($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++)
      do_trap({1'($urandom), 57'd0, 6'($urandom)}, {$urandom, $urandom},
              {$urandom, $urandom});

    // Trap raised mid-instruction, then reset during the mcause write.
    set_csr(12'h340, 64'h55);
    wq.delete();
    @(negedge CLK);
    REQ_VALID = 1'b1; FUNCT3 = 3'b001; CSR_ADDR = 12'h340; RS1_DATA = 64'hABCD;
    RS1_NZ = 1'b1; PRIVILEGE = 2'd3;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; TRAP_REQ = 1'b1; TRAP_CAUSE = 64'hB; TRAP_PC = 64'h2006;
    @(posedge CLK); #1;
    check("mid_wr_strobe", {63'd0, bus.CSR_LD_REG}, 64'd1);
    @(posedge CLK); #1;
    check("mid_rsp_valid", {63'd0, RSP_VALID}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("mid_no_trap", {63'd0, TRAP_DONE}, 64'd0);
      check("mid_rsp_held", {63'd0, RSP_VALID}, 64'd1);
    end
    check("mid_writes", 64'(wq.size()), 64'd1);
    @(negedge CLK);
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    check("mid_idle_ready", {63'd0, REQ_READY}, 64'd0);
    @(posedge CLK); #1;
    check("mid_epc_strobe", {63'd0, bus.CSR_LD_REG}, 64'd1);
    check("mid_epc_dr", {52'd0, bus.CSR_DR}, 64'h341);
    @(posedge CLK); #1;
    check("mid_cause_dr", {52'd0, bus.CSR_DR}, 64'h342);
    RST_N = 1'b0; TRAP_REQ = 1'b0;
    #1;
    check("mid_rst_ld", {63'd0, bus.CSR_LD_REG}, 64'd0);
    check("mid_rst_dr", {52'd0, bus.CSR_DR}, 64'd0);
    check("mid_rst_data", bus.CSR_DATA, 64'd0);
    check("mid_rst_ready", {63'd0, REQ_READY}, 64'd0);
    check("mid_rst_target", TRAP_TARGET, 64'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("post_rst_writes", 64'(wq.size()), 64'd2);
    if (wq.size() >= 2) begin
      check("post_rst_wr0", wq[0][63:0], 64'hABCD);
      check("post_rst_wr1", wq[1][63:0], 64'h2004);
    end
    check("post_rst_ready", {63'd0, REQ_READY}, 64'd1);
    check("post_rst_done", {63'd0, TRAP_DONE}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
